// File: rtl/rand_leaf_sink_if.sv
// Ready/valid bundle between the PRNG, the leaf sink and the ORAM frontend.
// The master side is the PRNG/frontend pair; the slave side is the sink.
interface rand_leaf_sink_if #(
  parameter int unsigned RandWidth = 32,
  parameter int unsigned LeafWidth = 20
);
  logic                 RandInValid;
  logic                 RandInReady;
  logic [RandWidth-1:0] RandIn;
  logic                 LeafReady;
  logic                 LeafValid;
  logic [LeafWidth-1:0] LeafOut;

  modport master (
    output RandInValid, RandIn, LeafReady,
    input  RandInReady, LeafValid, LeafOut
  );

  modport slave (
    input  RandInValid, RandIn, LeafReady,
    output RandInReady, LeafValid, LeafOut
  );
endinterface

// File: rtl/rand_leaf_sink.sv
// Packs PRNG words into leaf labels and buffers them for the ORAM remap logic.
// Random bits are used once; bits beyond LeafWidth are dropped.
module rand_leaf_sink #(
  parameter int unsigned RandWidth     = 32,
  parameter int unsigned LeafWidth     = 20,
  parameter int unsigned FIFODepth     = 4,
  parameter int unsigned StallCntWidth = 16
) (
  input  logic                     Clock,
  input  logic                     Reset,
  rand_leaf_sink_if.slave          Bus,
  output logic                     Starving,
  output logic [StallCntWidth-1:0] StarveCount
);

  localparam int unsigned WordsPerLeaf = (LeafWidth + RandWidth - 1) / RandWidth;
  localparam int unsigned CntWidth     = (WordsPerLeaf > 1) ? $clog2(WordsPerLeaf) : 1;
  localparam int unsigned AsmWidth     = WordsPerLeaf * RandWidth;
  localparam int unsigned PtrWidth     = $clog2(FIFODepth);
  localparam int unsigned CountWidth   = $clog2(FIFODepth + 1);
  localparam logic [CntWidth-1:0]   LastWord  = CntWidth'(WordsPerLeaf - 1);
  localparam logic [PtrWidth-1:0]   LastPtr   = PtrWidth'(FIFODepth - 1);
  localparam logic [CountWidth-1:0] FullCount = CountWidth'(FIFODepth);

  logic [CntWidth-1:0]   wordCnt;
  logic [AsmWidth-1:0]   assembly;
  logic [LeafWidth-1:0]  fifoMem [FIFODepth];
  logic [PtrWidth-1:0]   headPtr;
  logic [PtrWidth-1:0]   tailPtr;
  logic [CountWidth-1:0] count;

  logic                  isFinal;
  logic                  fifoFull;
  logic                  wordFire;
  logic                  push;
  logic                  pop;
  logic [LeafWidth-1:0]  newLeaf;

  // Modulo-FIFODepth pointer advance; handles non-power-of-2 depths.
  function automatic logic [PtrWidth-1:0] nextPtr(input logic [PtrWidth-1:0] p);
    return (p == LastPtr) ? '0 : p + PtrWidth'(1);
  endfunction

  // Handshake decode; ready never looks at LeafReady, so a full FIFO stalls FINAL words.
  always_comb begin
    isFinal         = (wordCnt == LastWord);
    fifoFull        = (count == FullCount);
    Bus.RandInReady = !Reset && (!isFinal || !fifoFull);
    Bus.LeafValid   = (count != '0);
    Bus.LeafOut     = fifoMem[headPtr];
    wordFire        = Bus.RandInValid && Bus.RandInReady;
    push            = wordFire && isFinal;
    pop             = Bus.LeafValid && Bus.LeafReady;
    // Final word sits above the collected words; upper slot of assembly is always zero.
    newLeaf         = LeafWidth'(assembly | (AsmWidth'(Bus.RandIn) << ((WordsPerLeaf - 1) * RandWidth)));
  end

  // Word collection: stores COLLECT words, clears after the final word completes a leaf.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      wordCnt  <= '0;
      assembly <= '0;
    end else if (wordFire) begin
      if (isFinal) begin
        wordCnt  <= '0;
        assembly <= '0;
      end else begin
        wordCnt <= wordCnt + CntWidth'(1);
        for (int unsigned k = 0; k + 1 < WordsPerLeaf; k++) begin
          if (wordCnt == CntWidth'(k)) begin
            assembly[k*RandWidth +: RandWidth] <= Bus.RandIn;
          end
        end
      end
    end
  end

  // Leaf FIFO: push on the final word, pop when the frontend takes the head.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      headPtr <= '0;
      tailPtr <= '0;
      count   <= '0;
      for (int unsigned i = 0; i < FIFODepth; i++) begin
        fifoMem[i] <= '0;
      end
    end else begin
      if (push) begin
        fifoMem[tailPtr] <= newLeaf;
        tailPtr          <= nextPtr(tailPtr);
      end
      if (pop) begin
        headPtr <= nextPtr(headPtr);
      end
      if (push && !pop) begin
        count <= count + CountWidth'(1);
      end else if (!push && pop) begin
        count <= count - CountWidth'(1);
      end
    end
  end

  // Starvation tracking: frontend asking while the buffer is empty.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      Starving    <= 1'b0;
      StarveCount <= '0;
    end else begin
      Starving <= Bus.LeafReady && !Bus.LeafValid;
      if (Bus.LeafReady && !Bus.LeafValid && (StarveCount != '1)) begin
        StarveCount <= StarveCount + StallCntWidth'(1);
      end
    end
  end

endmodule

// File: tb/tb_rand_leaf_sink.sv
// Directed bench for rand_leaf_sink: default config, a two-word leaf config,
// and a narrow-counter / depth-3 config.
module tb_rand_leaf_sink;

  logic Clock = 1'b0;
  logic rstA, rstB, rstC;
  logic        starvA, starvB, starvC;
  logic [15:0] scntA, scntB;
  logic [2:0]  scntC;

  int passCnt  = 0;
  int totalCnt = 0;

  always #5 Clock = ~Clock;

  rand_leaf_sink_if #(.RandWidth(32), .LeafWidth(20)) bA ();
  rand_leaf_sink_if #(.RandWidth(32), .LeafWidth(40)) bB ();
  rand_leaf_sink_if #(.RandWidth(32), .LeafWidth(20)) bC ();

  rand_leaf_sink dutA (
    .Clock(Clock), .Reset(rstA), .Bus(bA), .Starving(starvA), .StarveCount(scntA)
  );

  rand_leaf_sink #(.LeafWidth(40)) dutB (
    .Clock(Clock), .Reset(rstB), .Bus(bB), .Starving(starvB), .StarveCount(scntB)
  );

  rand_leaf_sink #(.FIFODepth(3), .StallCntWidth(3)) dutC (
    .Clock(Clock), .Reset(rstC), .Bus(bC), .Starving(starvC), .StarveCount(scntC)
  );

  typedef struct {
    logic        valid;
    logic [31:0] data;
    logic        ready;
    logic        expValid;
    logic [19:0] expLeaf;
    logic        expInReady;
    logic        expStarving;
    logic [15:0] expStarveCnt;
  } vec_t;

  vec_t vecs [8];

  task automatic tick();
    @(posedge Clock);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    totalCnt++;
    if (act === exp) passCnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  initial begin
    int acc;
    int nxt;
    logic rdy;

    rstA = 1'b1; rstB = 1'b1; rstC = 1'b1;
    bA.RandInValid = 1'b0; bA.RandIn = '0; bA.LeafReady = 1'b0;
    bB.RandInValid = 1'b0; bB.RandIn = '0; bB.LeafReady = 1'b0;
    bC.RandInValid = 1'b0; bC.RandIn = '0; bC.LeafReady = 1'b0;
    tick();
    tick();

    // Reset state
    chk("rst_leafvalid", 64'(bA.LeafValid), 64'd0);
    chk("rst_inready",   64'(bA.RandInReady), 64'd0);
    chk("rst_starving",  64'(starvA), 64'd0);
    chk("rst_starvecnt", 64'(scntA), 64'd0);
    chk("rst_leafout",   64'(bA.LeafOut), 64'd0);
    rstA = 1'b0; rstB = 1'b0; rstC = 1'b0;

    // Table: inputs applied for one edge, expected outputs after that edge
    vecs[0] = '{1'b1, 32'hDEADBEEF, 1'b1, 1'b1, 20'hDBEEF, 1'b1, 1'b1, 16'd1};
    vecs[1] = '{1'b0, 32'h0,        1'b1, 1'b0, 20'h0,     1'b1, 1'b0, 16'd1};
    vecs[2] = '{1'b1, 32'h00012345, 1'b0, 1'b1, 20'h12345, 1'b1, 1'b0, 16'd1};
    vecs[3] = '{1'b1, 32'hFFFABCDE, 1'b1, 1'b1, 20'hABCDE, 1'b1, 1'b0, 16'd1};
    vecs[4] = '{1'b1, 32'h00054321, 1'b1, 1'b1, 20'h54321, 1'b1, 1'b0, 16'd1};
    vecs[5] = '{1'b0, 32'h0,        1'b0, 1'b1, 20'h54321, 1'b1, 1'b0, 16'd1};
    vecs[6] = '{1'b0, 32'h0,        1'b1, 1'b0, 20'h0,     1'b1, 1'b0, 16'd1};
    vecs[7] = '{1'b0, 32'h0,        1'b1, 1'b0, 20'h0,     1'b1, 1'b1, 16'd2};

    for (int i = 0; i < 8; i++) begin
      bA.RandInValid = vecs[i].valid;
      bA.RandIn      = vecs[i].data;
      bA.LeafReady   = vecs[i].ready;
      tick();
      chk($sformatf("vec%0d_valid", i), 64'(bA.LeafValid), 64'(vecs[i].expValid));
      if (vecs[i].expValid)
        chk($sformatf("vec%0d_leaf", i), 64'(bA.LeafOut), 64'(vecs[i].expLeaf));
      chk($sformatf("vec%0d_inready", i), 64'(bA.RandInReady), 64'(vecs[i].expInReady));
      chk($sformatf("vec%0d_starving", i), 64'(starvA), 64'(vecs[i].expStarving));
      chk($sformatf("vec%0d_starvecnt", i), 64'(scntA), 64'(vecs[i].expStarveCnt));
    end

    // Full FIFO backpressure: 6 offered words, 4 accepted, word 5 held
    bA.LeafReady = 1'b0;
    bA.RandInValid = 1'b1;
    nxt = 1;
    acc = 0;
    for (int i = 0; i < 6; i++) begin
      bA.RandIn = 32'(nxt);
      #1 rdy = bA.RandInReady;
      tick();
      if (rdy) begin
        nxt++;
        acc++;
      end
    end
    chk("full_accepted", 64'(acc), 64'd4);
    chk("full_inready",  64'(bA.RandInReady), 64'd0);
    chk("full_head",     64'(bA.LeafOut), 64'd1);
    bA.LeafReady = 1'b1;
    tick();
    bA.LeafReady = 1'b0;
    chk("pop_inready", 64'(bA.RandInReady), 64'd1);
    chk("pop_head",    64'(bA.LeafOut), 64'd2);
    tick();
    chk("refill_inready", 64'(bA.RandInReady), 64'd0);
    bA.RandInValid = 1'b0;
    bA.LeafReady = 1'b1;
    for (int e = 2; e <= 5; e++) begin
      chk($sformatf("drain%0d_valid", e), 64'(bA.LeafValid), 64'd1);
      chk($sformatf("drain%0d_leaf", e), 64'(bA.LeafOut), 64'(e));
      tick();
    end
    chk("drain_empty", 64'(bA.LeafValid), 64'd0);

    // Starvation count on A (16-bit) and saturation on C (3-bit)
    bA.LeafReady = 1'b0;
    rstA = 1'b1;
    tick();
    rstA = 1'b0;
    bA.LeafReady = 1'b1;
    bC.LeafReady = 1'b1;
    repeat (10) tick();
    chk("starve_cnt10",  64'(scntA), 64'd10);
    chk("starve_flag",   64'(starvA), 64'd1);
    chk("starve_sat7",   64'(scntC), 64'd7);
    bA.LeafReady = 1'b0;
    bC.LeafReady = 1'b0;
    tick();
    chk("starve_clear", 64'(starvA), 64'd0);
    chk("starve_hold",  64'(scntA), 64'd10);
    chk("sat_hold",     64'(scntC), 64'd7);

    // Two-word leaf assembly
    bB.RandInValid = 1'b1;
    bB.RandIn = 32'h11223344;
    tick();
    chk("w2_first_noleaf", 64'(bB.LeafValid), 64'd0);
    chk("w2_first_ready",  64'(bB.RandInReady), 64'd1);
    bB.RandIn = 32'hAABBCCDD;
    tick();
    bB.RandInValid = 1'b0;
    chk("w2_leafvalid", 64'(bB.LeafValid), 64'd1);
    chk("w2_leaf",      64'(bB.LeafOut), 64'hDD11223344);
    bB.LeafReady = 1'b1;
    tick();
    bB.LeafReady = 1'b0;
    chk("w2_popped", 64'(bB.LeafValid), 64'd0);

    // Reset mid-assembly discards the partial leaf
    bB.RandInValid = 1'b1;
    bB.RandIn = 32'hCAFEF00D;
    tick();
    bB.RandInValid = 1'b0;
    rstB = 1'b1;
    #1 chk("midrst_inready", 64'(bB.RandInReady), 64'd0);
    tick();
    rstB = 1'b0;
    chk("midrst_noleaf", 64'(bB.LeafValid), 64'd0);
    bB.RandInValid = 1'b1;
    bB.RandIn = 32'h00000001;
    tick();
    chk("midrst_w1_noleaf", 64'(bB.LeafValid), 64'd0);
    bB.RandIn = 32'h00000002;
    tick();
    bB.RandInValid = 1'b0;
    chk("midrst_valid", 64'(bB.LeafValid), 64'd1);
    chk("midrst_leaf",  64'(bB.LeafOut), 64'h0200000001);

    // Depth-3 FIFO: pointer wrap keeps order
    bC.RandInValid = 1'b1;
    bC.RandIn = 32'hA;
    tick();
    bC.RandIn = 32'hB;
    tick();
    bC.RandIn = 32'hC;
    tick();
    bC.RandIn = 32'hD;
    #1;
    chk("d3_full_ready", 64'(bC.RandInReady), 64'd0);
    chk("d3_head_a",     64'(bC.LeafOut), 64'hA);
    bC.LeafReady = 1'b1;
    tick();
    bC.LeafReady = 1'b0;
    chk("d3_pop_ready", 64'(bC.RandInReady), 64'd1);
    tick();
    bC.RandInValid = 1'b0;
    chk("d3_refull_ready", 64'(bC.RandInReady), 64'd0);
    bC.LeafReady = 1'b1;
    for (int e = 11; e <= 13; e++) begin
      chk($sformatf("d3_drain%0d", e), 64'(bC.LeafOut), 64'(e));
      tick();
    end
    bC.LeafReady = 1'b0;
    chk("d3_empty", 64'(bC.LeafValid), 64'd0);

    $display("%0d/%0d checks passed", passCnt, totalCnt);
    $finish;
  end

endmodule
